// File: rtl/reward_scheduler.sv
// reward_scheduler
//   Sequences the reward packer. Packet-build triggers from the packet
//   filter, node-info role changes and local timers each set a sticky
//   pending bit. One job at a time is granted by fixed priority (lowest
//   bit index first). The packer gets a one-cycle enable, and the scheduler
//   waits for reward_done or a watchdog before the next grant. The block
//   also owns the HB lock and the MR/CHT cluster-formation timers.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   pkt_valid        one-cycle strobe: filtered packet fields valid
//   fPacketType      HB 000, INV 010, Data 101, SOS 110 (others ignored)
//   fHopsFromCH      hopsFromCH field of the received packet
//   iAmDestination   received packet addressed to this node
//   role             1 = cluster head
//   data_req         one-cycle strobe: own data to send
//   reward_done      packer finished the current job
//   rwd_en           one-cycle enable to the packer
//   fb_type          granted job code, held until the next grant
//   inv_hops_out     fHopsFromCH+1 latched when an INV is accepted
//   pending          [0]HB [1]INV [2]MR [3]FWD [4]CHINV [5]CHT [6]SRC
//   busy             high while a job is issued or awaited
//   wd_err           one-cycle pulse when the watchdog expires
module reward_scheduler #(
    parameter int WORD_WIDTH   = 16,
    parameter int MR_TIMEOUT   = 15,
    parameter int CHT_TIMEOUT  = 15,
    parameter int MAX_INV_HOPS = 4,
    parameter int WD_CYCLES    = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pkt_valid,
    input  logic [2:0]            fPacketType,
    input  logic [WORD_WIDTH-1:0] fHopsFromCH,
    input  logic                  iAmDestination,
    input  logic                  role,
    input  logic                  data_req,
    input  logic                  reward_done,
    output logic                  rwd_en,
    output logic [3:0]            fb_type,
    output logic [WORD_WIDTH-1:0] inv_hops_out,
    output logic [6:0]            pending,
    output logic                  busy,
    output logic                  wd_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    localparam logic [2:0] PT_HB   = 3'b000;
    localparam logic [2:0] PT_INV  = 3'b010;
    localparam logic [2:0] PT_DATA = 3'b101;
    localparam logic [2:0] PT_SOS  = 3'b110;

    localparam int J_HB = 0, J_INV = 1, J_MR = 2, J_FWD = 3, J_CHINV = 4, J_CHT = 5, J_SRC = 6;

    localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(WD_CYCLES - 1);
    localparam logic [WD_W-1:0]       WD_ONE   = WD_W'(1);
    localparam logic [WORD_WIDTH-1:0] W_ONE    = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] MR_LOAD  = WORD_WIDTH'(MR_TIMEOUT);
    localparam logic [WORD_WIDTH-1:0] CHT_LOAD = WORD_WIDTH'(CHT_TIMEOUT);
    localparam logic [WORD_WIDTH-1:0] HOPS_MAX = WORD_WIDTH'(MAX_INV_HOPS);

    state_e                state_q, state_d;
    logic                  rwd_en_q, rwd_en_d;
    logic                  busy_q, busy_d;
    logic [3:0]            fb_type_q, fb_type_d;
    logic [WORD_WIDTH-1:0] inv_hops_q, inv_hops_d;
    logic [6:0]            pend_q, pend_d;
    logic                  hb_lock_q, hb_lock_d;
    logic                  role_q, role_d;
    logic [WORD_WIDTH-1:0] mr_q, mr_d;
    logic [WORD_WIDTH-1:0] cht_q, cht_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;

    logic [6:0] set_vec, clr_vec;
    logic [2:0] grant_idx;
    logic       inv_ok, cht_load, wd_expire;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        rwd_en_d   = 1'b0;
        busy_d     = busy_q;
        fb_type_d  = fb_type_q;
        inv_hops_d = inv_hops_q;
        hb_lock_d  = hb_lock_q;
        role_d     = role;
        mr_d       = mr_q;
        cht_d      = cht_q;
        wd_cnt_d   = wd_cnt_q;
        set_vec    = '0;
        clr_vec    = '0;
        grant_idx  = '0;
        inv_ok     = 1'b0;
        cht_load   = 1'b0;
        wd_expire  = 1'b0;

        // Scan downwards so the last hit, i.e. the lowest set index, wins.
        for (int i = 6; i >= 0; i--) begin
            if (pend_q[i]) grant_idx = 3'(i);
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d            = S_ISSUE;
                    fb_type_d          = {1'b0, grant_idx};
                    clr_vec[grant_idx] = 1'b1;
                    rwd_en_d           = 1'b1;
                    busy_d             = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT;
                wd_cnt_d = '0;
            end
            S_WAIT: begin
                if (reward_done) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    cht_load = (fb_type_q == 4'(J_CHINV)) && role;
                end else if (wd_cnt_q == WD_LAST) begin
                    // Job is dropped: not re-queued and the CHT timer stays idle.
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    wd_expire = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // HB is locked out after one acceptance until a Data packet is seen.
        if (pkt_valid && (fPacketType == PT_HB) && !hb_lock_q) begin
            set_vec[J_HB] = 1'b1;
            hb_lock_d     = 1'b1;
        end
        if (pkt_valid && (fPacketType == PT_DATA)) hb_lock_d = 1'b0;

        inv_ok = pkt_valid && (fPacketType == PT_INV) && (fHopsFromCH < HOPS_MAX);
        if (inv_ok) begin
            set_vec[J_INV] = 1'b1;
            inv_hops_d     = fHopsFromCH + W_ONE;
        end

        set_vec[J_FWD]   = pkt_valid && iAmDestination &&
                           ((fPacketType == PT_DATA) || (fPacketType == PT_SOS));
        set_vec[J_CHINV] = role && !role_q;
        set_vec[J_SRC]   = data_req;

        // MR timer: member-only. A running timer ignores further INVs.
        if (role) begin
            mr_d          = '0;
            clr_vec[J_MR] = 1'b1;
        end else if (inv_ok && (mr_q == '0)) begin
            mr_d = MR_LOAD;
        end else if (mr_q != '0) begin
            mr_d          = mr_q - W_ONE;
            set_vec[J_MR] = (mr_q == W_ONE);
        end

        // CHT timer: cluster-head only; losing the role flushes CH work.
        if (!role) begin
            cht_d            = '0;
            clr_vec[J_CHINV] = 1'b1;
            clr_vec[J_CHT]   = 1'b1;
        end else if (cht_load) begin
            cht_d = CHT_LOAD;
        end else if (cht_q != '0) begin
            cht_d          = cht_q - W_ONE;
            set_vec[J_CHT] = (cht_q == W_ONE);
        end

        // A new trigger on the bit being granted or cleared survives.
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: all state here is small control logic, so every flop is reset.
            state_q    <= S_IDLE;
            rwd_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            fb_type_q  <= 4'b0111;
            inv_hops_q <= '0;
            pend_q     <= '0;
            hb_lock_q  <= 1'b0;
            role_q     <= 1'b0;
            mr_q       <= '0;
            cht_q      <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rwd_en_q   <= rwd_en_d;
            busy_q     <= busy_d;
            fb_type_q  <= fb_type_d;
            inv_hops_q <= inv_hops_d;
            pend_q     <= pend_d;
            hb_lock_q  <= hb_lock_d;
            role_q     <= role_d;
            mr_q       <= mr_d;
            cht_q      <= cht_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign rwd_en       = rwd_en_q;
    assign busy         = busy_q;
    assign fb_type      = fb_type_q;
    assign inv_hops_out = inv_hops_q;
    assign pending      = pend_q;
    // Flags the expiring WAIT cycle itself, i.e. WD_CYCLES cycles after rwd_en.
    assign wd_err       = wd_expire;

endmodule
